inst_decode: RTL and testbench
==============================

// Module: inst_decode
// PURPOSE
//  RV32I instruction-decode stage; consumes IfId_Inst/IfId_Pc from the fetch stage and loads the ID/EX pipeline register.
//  Holds the 32x32 register file (WB write port), generates immediates and control, and detects load-use hazards.
//  On a load-use hazard it drives Id_PcWrite low for exactly one cycle and inserts a bubble into ID/EX.
// PARAMETERS
//  DATA_W      32  datapath / register width
//  REG_ADDR_W  5   register index width (2**REG_ADDR_W registers)
// PORTS
//  clk            in   1       clock, rising edge
//  rstb           in   1       reset, asynchronous, active-low
//  Flush          in   1       branch/jump taken in EX; kill ID/EX contents
//  IfId_Inst      in   32      instruction from IF/ID
//  IfId_Pc        in   32      PC of IfId_Inst
//  Wb_RegWrite    in   1       WB register write enable
//  Wb_Rd          in   5       WB destination index
//  Wb_Data        in   DATA_W  WB write data
//  Id_PcWrite     out  1       PC update enable to fetch (0 = stall)
//  IdEx_Pc        out  32      registered PC
//  IdEx_Rs1Data   out  DATA_W  registered rs1 value
//  IdEx_Rs2Data   out  DATA_W  registered rs2 value
//  IdEx_Imm       out  32      registered sign-extended immediate
//  IdEx_Rs1/Rs2/Rd out 5 each  registered register indices (for forwarding)
//  IdEx_Funct3    out  3       registered funct3 (branch compare / mem size)
//  IdEx_AluOp     out  4       0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  IdEx_ASel      out  1       ALU A: 0 rs1, 1 PC
//  IdEx_BSel      out  1       ALU B: 0 rs2, 1 imm
//  IdEx_MemRead/MemWrite/RegWrite/Branch/Jump  out 1 each  registered control
//  IdEx_WbSel     out  2       0 ALU, 1 MEM, 2 PC+4
//  IdEx_Illegal   out  1       unrecognised opcode
// BEHAVIOUR
//  - Reset: every IdEx_* output is 0 (bubble = all-zero control); Id_PcWrite is combinational and evaluates to 1 out of reset.
//  - Register file: x0 reads 0; a write to x0 is ignored; writes occur on the clk edge when Wb_RegWrite=1; no reset of contents.
//  - Immediates: I/S/B/U/J per RV32I; B and J bit0=0; sign-extended from inst[31]; R-type imm=0.
//  - Decode: LUI: PASSB, BSel=1. AUIPC: ADD, ASel=1, BSel=1. JAL: ADD, PC+imm, Jump=1, WbSel=2.
//    JALR: ADD, rs1+imm, Jump=1, WbSel=2. Branch: ADD, PC+imm, Branch=1, RegWrite=0.
//    Load: ADD, BSel=1, MemRead=1, WbSel=1. Store: ADD, BSel=1, MemWrite=1. OP/OP-IMM: funct3/funct7[5] map; SUB only for R-type.
//  - Rs1/Rs2 are marked "used" only for formats that read them (rs2 for R/S/B; rs1 for all but U/J).
//  - Illegal opcode: IdEx_Illegal=1 with RegWrite/MemRead/MemWrite/Branch/Jump=0.
//  - Load-use hazard (combinational): IdEx_MemRead & IdEx_Rd!=0 & (IdEx_Rd==rs1 used | IdEx_Rd==rs2 used).
//    Response: Id_PcWrite=0 and bubble loaded into ID/EX on the next edge. Fetch re-presents the same instruction, which proceeds the following cycle; stall length is exactly 1.
//  - Latency: one cycle, IfId_* -> IdEx_*.
//  - Flush=1: ID/EX loads a bubble (all zero) regardless of hazard. Id_PcWrite is forced to 1 so the redirect is taken. Flush has priority over stall.
//  - Reset asserted mid-operation clears ID/EX immediately (async); register file contents are undefined after reset.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a same-cycle WB write to rs1/rs2 (Wb_RegWrite=1, Wb_Rd!=0, index match) returns Wb_Data on the read port (write-first).
//  REGFILE_BYPASS_EN undefined: read ports return the pre-write value; EX forwarding must cover the 3-cycle distance.
// TESTING
//  1 reset, then IfId_Inst=0x00500093 (addi x1,x0,5) -> next cycle IdEx_Rd=1, Imm=5, AluOp=0, BSel=1, RegWrite=1.
//  2 lw x2,0(x1) then add x3,x2,x1 back-to-back -> Id_PcWrite=0 one cycle; bubble in ID/EX; add appears in ID/EX one cycle later.
//  3 WB writes x5=0xDEADBEEF while ID reads x5 -> IdEx_Rs1Data=0xDEADBEEF with REGFILE_BYPASS_EN, old value without it.
//  4 write x0=0x1234, then read x0 -> IdEx_Rs1Data=0.
//  5 Flush=1 coincident with a load-use hazard -> ID/EX all-zero, Id_PcWrite=1.
//  6 jal x1,-8 at PC 0x100 (0xFF9FF0EF) -> Imm=0xFFFFFFF8, ASel=1, Jump=1, WbSel=2; opcode 0x7F -> Illegal=1, RegWrite=0.

Source files
------------

// File: rtl/inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : inst_decode
// Brief    : RV32I decode stage: register file, immediate/control generation,
//            load-use stall and the ID/EX pipeline register.
// Options  : REGFILE_BYPASS_EN - write-first bypass of a same-cycle WB write.
// Revision : 1.0 - initial release
// ============================================================================
module inst_decode #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  Flush,
    input  logic [31:0]           IfId_Inst,
    input  logic [31:0]           IfId_Pc,
    input  logic                  Wb_RegWrite,
    input  logic [REG_ADDR_W-1:0] Wb_Rd,
    input  logic [DATA_W-1:0]     Wb_Data,
    output logic                  Id_PcWrite,
    output logic [31:0]           IdEx_Pc,
    output logic [DATA_W-1:0]     IdEx_Rs1Data,
    output logic [DATA_W-1:0]     IdEx_Rs2Data,
    output logic [31:0]           IdEx_Imm,
    output logic [REG_ADDR_W-1:0] IdEx_Rs1,
    output logic [REG_ADDR_W-1:0] IdEx_Rs2,
    output logic [REG_ADDR_W-1:0] IdEx_Rd,
    output logic [2:0]            IdEx_Funct3,
    output logic [3:0]            IdEx_AluOp,
    output logic                  IdEx_ASel,
    output logic                  IdEx_BSel,
    output logic                  IdEx_MemRead,
    output logic                  IdEx_MemWrite,
    output logic                  IdEx_RegWrite,
    output logic                  IdEx_Branch,
    output logic                  IdEx_Jump,
    output logic [1:0]            IdEx_WbSel,
    output logic                  IdEx_Illegal
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    localparam int c_NREGS = 2 ** REG_ADDR_W;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_f7b5;
    logic [REG_ADDR_W-1:0] w_rs1;
    logic [REG_ADDR_W-1:0] w_rs2;
    logic [REG_ADDR_W-1:0] w_rd;

    assign w_opcode = IfId_Inst[6:0];
    assign w_funct3 = IfId_Inst[14:12];
    assign w_f7b5   = IfId_Inst[30];
    assign w_rs1    = IfId_Inst[15 +: REG_ADDR_W];
    assign w_rs2    = IfId_Inst[20 +: REG_ADDR_W];
    assign w_rd     = IfId_Inst[7 +: REG_ADDR_W];

    // Register file: no reset, x0 is never written and always reads zero
    logic [DATA_W-1:0] r_regs [c_NREGS];
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;

    always_ff @(posedge clk) begin
        if (Wb_RegWrite && (Wb_Rd != '0)) begin
            r_regs[Wb_Rd] <= Wb_Data;
        end
    end

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != '0) begin
            w_rs1_data = r_regs[w_rs1];
`ifdef REGFILE_BYPASS_EN
            if (Wb_RegWrite && (Wb_Rd == w_rs1)) w_rs1_data = Wb_Data;
`endif
        end
        if (w_rs2 != '0) begin
            w_rs2_data = r_regs[w_rs2];
`ifdef REGFILE_BYPASS_EN
            if (Wb_RegWrite && (Wb_Rd == w_rs2)) w_rs2_data = Wb_Data;
`endif
        end
    end

    // Immediate formats
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_imm_i = {{20{IfId_Inst[31]}}, IfId_Inst[31:20]};
    assign w_imm_s = {{20{IfId_Inst[31]}}, IfId_Inst[31:25], IfId_Inst[11:7]};
    assign w_imm_b = {{19{IfId_Inst[31]}}, IfId_Inst[31], IfId_Inst[7],
                      IfId_Inst[30:25], IfId_Inst[11:8], 1'b0};
    assign w_imm_u = {IfId_Inst[31:12], 12'h000};
    assign w_imm_j = {{11{IfId_Inst[31]}}, IfId_Inst[31], IfId_Inst[19:12],
                      IfId_Inst[20], IfId_Inst[30:21], 1'b0};

    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic [3:0]  w_alu_arith;
    logic        w_a_sel;
    logic        w_b_sel;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_reg_write;
    logic        w_branch;
    logic        w_jump;
    logic [1:0]  w_wb_sel;
    logic        w_illegal;
    logic        w_use_rs1;
    logic        w_use_rs2;

    // funct3/funct7[5] arithmetic map; SUB only exists for register-register
    always_comb begin
        w_alu_arith = c_ALU_ADD;
        case (w_funct3)
            3'd0: w_alu_arith = (w_opcode == c_OP_REG && w_f7b5) ? c_ALU_SUB : c_ALU_ADD;
            3'd1: w_alu_arith = c_ALU_SLL;
            3'd2: w_alu_arith = c_ALU_SLT;
            3'd3: w_alu_arith = c_ALU_SLTU;
            3'd4: w_alu_arith = c_ALU_XOR;
            3'd5: w_alu_arith = w_f7b5 ? c_ALU_SRA : c_ALU_SRL;
            3'd6: w_alu_arith = c_ALU_OR;
            default: w_alu_arith = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_imm       = '0;
        w_alu_op    = c_ALU_ADD;
        w_a_sel     = 1'b0;
        w_b_sel     = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_wb_sel    = c_WB_ALU;
        w_illegal   = 1'b0;
        case (w_opcode)
            c_OP_LUI: begin
                w_imm = w_imm_u; w_alu_op = c_ALU_PASSB; w_b_sel = 1'b1; w_reg_write = 1'b1;
            end
            c_OP_AUIPC: begin
                w_imm = w_imm_u; w_a_sel = 1'b1; w_b_sel = 1'b1; w_reg_write = 1'b1;
            end
            c_OP_JAL: begin
                w_imm = w_imm_j; w_a_sel = 1'b1; w_b_sel = 1'b1;
                w_jump = 1'b1; w_reg_write = 1'b1; w_wb_sel = c_WB_PC4;
            end
            c_OP_JALR: begin
                w_imm = w_imm_i; w_b_sel = 1'b1;
                w_jump = 1'b1; w_reg_write = 1'b1; w_wb_sel = c_WB_PC4;
            end
            c_OP_BRANCH: begin
                w_imm = w_imm_b; w_a_sel = 1'b1; w_b_sel = 1'b1; w_branch = 1'b1;
            end
            c_OP_LOAD: begin
                w_imm = w_imm_i; w_b_sel = 1'b1; w_mem_read = 1'b1;
                w_reg_write = 1'b1; w_wb_sel = c_WB_MEM;
            end
            c_OP_STORE: begin
                w_imm = w_imm_s; w_b_sel = 1'b1; w_mem_write = 1'b1;
            end
            c_OP_IMM: begin
                w_imm = w_imm_i; w_alu_op = w_alu_arith; w_b_sel = 1'b1; w_reg_write = 1'b1;
            end
            c_OP_REG: begin
                w_alu_op = w_alu_arith; w_reg_write = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_use_rs1 = !((w_opcode == c_OP_LUI) || (w_opcode == c_OP_AUIPC) || (w_opcode == c_OP_JAL));
    assign w_use_rs2 = (w_opcode == c_OP_REG) || (w_opcode == c_OP_STORE) || (w_opcode == c_OP_BRANCH);

    logic w_hazard;
    logic w_bubble;

    assign w_hazard = IdEx_MemRead && (IdEx_Rd != '0) &&
                      (((IdEx_Rd == w_rs1) && w_use_rs1) || ((IdEx_Rd == w_rs2) && w_use_rs2));
    // Flush wins so the redirect is never lost behind a stall
    assign Id_PcWrite = Flush || !w_hazard;
    assign w_bubble   = Flush || w_hazard;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb || w_bubble) begin
            IdEx_Pc       <= '0;
            IdEx_Rs1Data  <= '0;
            IdEx_Rs2Data  <= '0;
            IdEx_Imm      <= '0;
            IdEx_Rs1      <= '0;
            IdEx_Rs2      <= '0;
            IdEx_Rd       <= '0;
            IdEx_Funct3   <= '0;
            IdEx_AluOp    <= '0;
            IdEx_ASel     <= 1'b0;
            IdEx_BSel     <= 1'b0;
            IdEx_MemRead  <= 1'b0;
            IdEx_MemWrite <= 1'b0;
            IdEx_RegWrite <= 1'b0;
            IdEx_Branch   <= 1'b0;
            IdEx_Jump     <= 1'b0;
            IdEx_WbSel    <= '0;
            IdEx_Illegal  <= 1'b0;
        end else begin
            IdEx_Pc       <= IfId_Pc;
            IdEx_Rs1Data  <= w_rs1_data;
            IdEx_Rs2Data  <= w_rs2_data;
            IdEx_Imm      <= w_imm;
            IdEx_Rs1      <= w_rs1;
            IdEx_Rs2      <= w_rs2;
            IdEx_Rd       <= w_rd;
            IdEx_Funct3   <= w_funct3;
            IdEx_AluOp    <= w_alu_op;
            IdEx_ASel     <= w_a_sel;
            IdEx_BSel     <= w_b_sel;
            IdEx_MemRead  <= w_mem_read;
            IdEx_MemWrite <= w_mem_write;
            IdEx_RegWrite <= w_reg_write;
            IdEx_Branch   <= w_branch;
            IdEx_Jump     <= w_jump;
            IdEx_WbSel    <= w_wb_sel;
            IdEx_Illegal  <= w_illegal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_decode
// Brief    : Random + directed self-checking bench for inst_decode against a
//            behavioural decode/hazard model (honours REGFILE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_decode;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] IfId_Inst = 32'h0000_0013;
    logic [31:0] IfId_Pc = '0;
    logic        Wb_RegWrite = 1'b0;
    logic [4:0]  Wb_Rd = '0;
    logic [31:0] Wb_Data = '0;
    logic        Id_PcWrite;
    logic [31:0] IdEx_Pc, IdEx_Rs1Data, IdEx_Rs2Data, IdEx_Imm;
    logic [4:0]  IdEx_Rs1, IdEx_Rs2, IdEx_Rd;
    logic [2:0]  IdEx_Funct3;
    logic [3:0]  IdEx_AluOp;
    logic        IdEx_ASel, IdEx_BSel, IdEx_MemRead, IdEx_MemWrite, IdEx_RegWrite;
    logic        IdEx_Branch, IdEx_Jump, IdEx_Illegal;
    logic [1:0]  IdEx_WbSel;

    inst_decode #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rstb(rstb), .Flush(Flush), .IfId_Inst(IfId_Inst), .IfId_Pc(IfId_Pc),
        .Wb_RegWrite(Wb_RegWrite), .Wb_Rd(Wb_Rd), .Wb_Data(Wb_Data),
        .Id_PcWrite(Id_PcWrite), .IdEx_Pc(IdEx_Pc), .IdEx_Rs1Data(IdEx_Rs1Data),
        .IdEx_Rs2Data(IdEx_Rs2Data), .IdEx_Imm(IdEx_Imm), .IdEx_Rs1(IdEx_Rs1),
        .IdEx_Rs2(IdEx_Rs2), .IdEx_Rd(IdEx_Rd), .IdEx_Funct3(IdEx_Funct3),
        .IdEx_AluOp(IdEx_AluOp), .IdEx_ASel(IdEx_ASel), .IdEx_BSel(IdEx_BSel),
        .IdEx_MemRead(IdEx_MemRead), .IdEx_MemWrite(IdEx_MemWrite),
        .IdEx_RegWrite(IdEx_RegWrite), .IdEx_Branch(IdEx_Branch), .IdEx_Jump(IdEx_Jump),
        .IdEx_WbSel(IdEx_WbSel), .IdEx_Illegal(IdEx_Illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        asel, bsel, mr, mw, rw, br, jp;
        logic [1:0]  wb;
        logic        ill, k1, k2;
    } exp_t;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    // Behavioural decode: expected ID/EX fields for one instruction
    function automatic exp_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e = '0;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        int arith [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int alu_a;
        imm_i = sext({20'h0, inst[31:20]}, 12);
        imm_s = sext({20'h0, inst[31:25], inst[11:7]}, 12);
        imm_b = sext({19'h0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
        imm_u = inst & 32'hFFFF_F000;
        imm_j = sext({11'h0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
        alu_a = arith[inst[14:12]];
        if (inst[14:12] == 3'd5 && inst[30]) alu_a = 7;
        e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7]; e.f3 = inst[14:12];
        case (inst[6:0])
            7'h37: begin e.imm = imm_u; e.alu = 4'd10; e.bsel = 1; e.rw = 1; end
            7'h17: begin e.imm = imm_u; e.asel = 1; e.bsel = 1; e.rw = 1; end
            7'h6F: begin e.imm = imm_j; e.asel = 1; e.bsel = 1; e.jp = 1; e.rw = 1; e.wb = 2; end
            7'h67: begin e.imm = imm_i; e.bsel = 1; e.jp = 1; e.rw = 1; e.wb = 2; end
            7'h63: begin e.imm = imm_b; e.asel = 1; e.bsel = 1; e.br = 1; end
            7'h03: begin e.imm = imm_i; e.bsel = 1; e.mr = 1; e.rw = 1; e.wb = 1; end
            7'h23: begin e.imm = imm_s; e.bsel = 1; e.mw = 1; end
            7'h13: begin e.imm = imm_i; e.alu = 4'(alu_a); e.bsel = 1; e.rw = 1; end
            7'h33: begin
                e.alu = (inst[14:12] == 3'd0 && inst[30]) ? 4'd1 : 4'(alu_a);
                e.rw = 1;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction
    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    // Model state
    exp_t        cur = '0;
    logic [31:0] mrf [32];
    bit          mval [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic model_read(input logic [4:0] idx, output logic [31:0] v, output logic k);
        if (idx == 0) begin v = 0; k = 1; end
        else if (BYPASS && Wb_RegWrite && Wb_Rd == idx) begin v = Wb_Data; k = 1; end
        else begin v = mrf[idx]; k = mval[idx]; end
    endtask

    // Single compare process: check outputs each cycle, then advance the model
    always @(negedge clk) begin
        exp_t nxt;
        bit   haz;
        if (!rstb) begin
            cur = '0;
            for (int i = 0; i < 32; i++) mval[i] = 0;
        end
        chk("idex_pc", IdEx_Pc, cur.pc);
        if (cur.rs1d == 0 && cur.rs1 == 0 || cur.k1 || (cur == '0)) ;
        if (cur.k1 || cur == '0) chk("idex_rs1data", IdEx_Rs1Data, cur.rs1d);
        if (cur.k2 || cur == '0) chk("idex_rs2data", IdEx_Rs2Data, cur.rs2d);
        chk("idex_imm", IdEx_Imm, cur.imm);
        chk("idex_idx", {IdEx_Rs1, IdEx_Rs2, IdEx_Rd, IdEx_Funct3}, {cur.rs1, cur.rs2, cur.rd, cur.f3});
        chk("idex_alu", IdEx_AluOp, cur.alu);
        chk("idex_ctrl", {IdEx_ASel, IdEx_BSel, IdEx_MemRead, IdEx_MemWrite, IdEx_RegWrite,
                          IdEx_Branch, IdEx_Jump, IdEx_WbSel, IdEx_Illegal},
            {cur.asel, cur.bsel, cur.mr, cur.mw, cur.rw, cur.br, cur.jp, cur.wb, cur.ill});
        if (!rstb) begin
            chk("pcwrite_reset", Id_PcWrite, 1);
        end else begin
            haz = cur.mr && cur.rd != 0 &&
                  ((cur.rd == IfId_Inst[19:15] && reads_rs1(IfId_Inst[6:0])) ||
                   (cur.rd == IfId_Inst[24:20] && reads_rs2(IfId_Inst[6:0])));
            chk("pcwrite", Id_PcWrite, Flush || !haz);
            if (Flush || haz) begin
                nxt = '0;
            end else begin
                nxt = model_decode(IfId_Inst, IfId_Pc);
                model_read(nxt.rs1, nxt.rs1d, nxt.k1);
                model_read(nxt.rs2, nxt.rs2d, nxt.k2);
            end
            if (Wb_RegWrite && Wb_Rd != 0) begin
                mrf[Wb_Rd]  = Wb_Data;
                mval[Wb_Rd] = 1;
            end
            cur = nxt;
        end
    end

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic fl,
                         input logic we, input logic [4:0] rd, input logic [31:0] d);
        @(posedge clk);
        #1;
        IfId_Inst = inst; IfId_Pc = pc; Flush = fl;
        Wb_RegWrite = we; Wb_Rd = rd; Wb_Data = d;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW  = 32'h0000_A103;   // lw  x2,0(x1)
    localparam logic [31:0] ADD = 32'h0011_01B3;   // add x3,x2,x1

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [31:0] w = $urandom;
        logic [6:0]  op;
        if ($urandom_range(0, 19) == 0) begin
            op = 7'h7F;
            if ($urandom_range(0, 1) == 1) op = 7'h73;
        end else begin
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 2) == 0) op = 7'h03;
        end
        w[6:0]   = op;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        logic [31:0] ri, rp;
        bit stall;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_regwrite", IdEx_RegWrite, 0);
        chk("reset_pcwrite", Id_PcWrite, 1);
        @(posedge clk); #1 rstb = 1'b1;

        // 1: addi x1,x0,5
        drive(32'h0050_0093, 32'h0, 0, 0, 0, 0);
        drive(NOP, 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_rd", IdEx_Rd, 1);
        chk("t1_imm", IdEx_Imm, 5);
        chk("t1_alu_bsel_rw", {IdEx_AluOp, IdEx_BSel, IdEx_RegWrite}, {4'd0, 1'b1, 1'b1});

        // Preload register file
        for (int r = 1; r < 32; r++) drive(NOP, 32'h8, 0, 1, 5'(r), $urandom);

        // 2: load-use stall of exactly one cycle
        drive(LW, 32'h10, 0, 0, 0, 0);
        drive(ADD, 32'h14, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_stall", Id_PcWrite, 0);
        chk("t2_load_in_ex", IdEx_MemRead, 1);
        drive(ADD, 32'h14, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_bubble", {IdEx_RegWrite, IdEx_MemRead, IdEx_Rd, IdEx_Pc}, 0);
        chk("t2_resume", Id_PcWrite, 1);
        drive(NOP, 32'h18, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_add_in_ex", {IdEx_Rd, IdEx_Rs1, IdEx_Pc}, {5'd3, 5'd2, 32'h14});

        // 3: same-cycle WB write to x5 while decoding addi x6,x5,0
        drive(NOP, 32'h20, 0, 1, 5'd5, 32'h1111_1111);
        drive(32'h0002_8313, 32'h24, 0, 1, 5'd5, 32'hDEAD_BEEF);
        drive(NOP, 32'h28, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_bypass", IdEx_Rs1Data, BYPASS ? 32'hDEAD_BEEF : 32'h1111_1111);

        // 4: x0 is hard-wired
        drive(NOP, 32'h30, 0, 1, 5'd0, 32'h1234);
        drive(32'h0000_0393, 32'h34, 0, 0, 0, 0);
        drive(NOP, 32'h38, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_x0", IdEx_Rs1Data, 0);

        // 5: flush beats a coincident load-use hazard
        drive(LW, 32'h40, 0, 0, 0, 0);
        drive(ADD, 32'h44, 1, 0, 0, 0);
        @(negedge clk);
        chk("t5_pcwrite", Id_PcWrite, 1);
        drive(NOP, 32'h48, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_bubble", {IdEx_Pc ^ IdEx_Imm, 4'(IdEx_AluOp), IdEx_Rd, IdEx_MemRead, IdEx_RegWrite}, 0);

        // 6: jal x1,-8 then an illegal opcode
        drive(32'hFF9F_F0EF, 32'h100, 0, 0, 0, 0);
        drive(32'h0000_007F, 32'h104, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_jal_imm", IdEx_Imm, 32'hFFFF_FFF8);
        chk("t6_jal_ctrl", {IdEx_ASel, IdEx_Jump, IdEx_WbSel}, {1'b1, 1'b1, 2'd2});
        drive(NOP, 32'h108, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_illegal", {IdEx_Illegal, IdEx_RegWrite}, {1'b1, 1'b0});

        // Random traffic with fetch re-presenting on stall and one async reset
        ri = NOP; rp = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stall = !Id_PcWrite;
            if (n == 1500) begin
                #2;
                rstb = 1'b0; Wb_RegWrite = 1'b0;
                repeat (2) @(negedge clk);
                @(posedge clk); #1 rstb = 1'b1;
                stall = 0;
            end
            if (!stall) begin
                ri = rand_inst();
                rp = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            drive(ri, rp, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
        end
        drive(NOP, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
